// File: rtl/acq_sequencer.sv
// Acquisition buffer sequencer: arms the buffer, paces sample writes,
// arbitrates word reads for the readout side and tracks the unread fill level.
module acq_sequencer #(
  parameter int DEPTH       = 256,
  parameter int CAPTURE_LEN = 192,
  parameter int SAMPLE_DIV  = 8,
  parameter int ARM_CYCLES  = 4,
  parameter int RD_LAT      = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     rd_req,
  output logic                     begin_acq,
  output logic                     wr_strobe,
  output logic                     rd_strobe,
  output logic                     rd_valid,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     empty,
  output logic                     full,
  output logic                     overflow,
  output logic                     busy,
  output logic                     done
);

  localparam int FW = $clog2(DEPTH) + 1;
  localparam int DW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int CW = $clog2(CAPTURE_LEN + 1);
  localparam int AW = $clog2(ARM_CYCLES + 1);

  typedef enum logic [2:0] {S_IDLE, S_ARM, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic              start_q;
  logic [DW-1:0]     div_q, div_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [AW-1:0]     arm_q, arm_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic              ovf_q, ovf_d;
  logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;

  logic slot, rd_inflight, rd_phase;

  // Strobe and status decode; everything is derived from registered state so
  // each strobe lasts exactly one clock.
  always_comb begin
    slot        = (state_q == S_RUN) && (div_q == DW'(SAMPLE_DIV - 1));
    full        = (fill_q == FW'(DEPTH));
    empty       = (fill_q < FW'(4));
    rd_phase    = (state_q == S_RUN) || (state_q == S_DRAIN);
    // A read blocks the next one until its data has been presented, which
    // also keeps rd_strobe low for at least one clock between pulses.
    rd_inflight = |rd_pipe_q;
    wr_strobe   = slot && !full;
    rd_strobe   = rd_phase && rd_req && !empty && !rd_inflight;
    rd_valid    = rd_pipe_q[RD_LAT-1];
    begin_acq   = rd_phase;
    busy        = (state_q != S_IDLE);
    done        = (state_q == S_DONE);
    fill        = fill_q;
    overflow    = ovf_q;
  end

  // Read latency shift register: rd_valid is the strobe delayed RD_LAT clocks.
  always_comb begin
    rd_pipe_d    = rd_pipe_q << 1;
    rd_pipe_d[0] = rd_strobe;
  end

  // Next-state, counters and fill bookkeeping.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    wcnt_d  = wcnt_q;
    arm_d   = arm_q;
    ovf_d   = ovf_q;
    unique case ({wr_strobe, rd_strobe})
      2'b10:   fill_d = fill_q + FW'(1);
      2'b01:   fill_d = fill_q - FW'(4);
      2'b11:   fill_d = fill_q - FW'(3);
      default: fill_d = fill_q;
    endcase
    unique case (state_q)
      S_IDLE: begin
        if (start && !start_q) begin
          state_d = S_ARM;
          arm_d   = '0;
          div_d   = '0;
          wcnt_d  = '0;
          fill_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      S_ARM: begin
        arm_d = arm_q + AW'(1);
        if (arm_q == AW'(ARM_CYCLES - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        div_d = slot ? '0 : div_q + DW'(1);
        // A suppressed slot still consumes one of the CAPTURE_LEN slots.
        if (slot) begin
          wcnt_d = wcnt_q + CW'(1);
          if (full) ovf_d = 1'b1;
        end
        if (stop || (slot && (wcnt_q == CW'(CAPTURE_LEN - 1)))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        // Residual samples short of a whole word are discarded.
        if (empty) begin
          fill_d  = '0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      start_q   <= 1'b0;
      div_q     <= '0;
      wcnt_q    <= '0;
      arm_q     <= '0;
      fill_q    <= '0;
      ovf_q     <= 1'b0;
      rd_pipe_q <= '0;
    end else begin
      state_q   <= state_d;
      start_q   <= start;
      div_q     <= div_d;
      wcnt_q    <= wcnt_d;
      arm_q     <= arm_d;
      fill_q    <= fill_d;
      ovf_q     <= ovf_d;
      rd_pipe_q <= rd_pipe_d;
    end
  end

endmodule

// File: tb/tb_acq_sequencer.sv
// Bench for acq_sequencer: a default-parameter instance and a small fast
// instance share stimulus; each is compared every cycle against a
// transaction-level model of the capture rules.
module tb_acq_sequencer;

  // instance 0: defaults; instance 1: small buffer, SAMPLE_DIV=2
  localparam int D1 = 16, L1 = 32, V1 = 2, A1 = 2, R1 = 3;

  int c_dp [2] = '{256, D1};
  int c_ln [2] = '{192, L1};
  int c_dv [2] = '{8,   V1};
  int c_ac [2] = '{4,   A1};
  int c_rl [2] = '{3,   R1};

  localparam int P_IDLE = 0, P_ARM = 1, P_RUN = 2, P_DRAIN = 3, P_DONE = 4;

  typedef struct {
    int phase;
    int cnt;
    int slots;
    int fill;
    bit ovf;
    bit st_prev;
    int due;
    int last_rd;
  } mdl_t;

  logic clk = 1'b0;
  logic rst_n, start, stop, rd_req;

  logic b0, w0, r0, v0, e0, f0, o0, y0, d0;
  logic [8:0] fl0;
  logic b1, w1, r1, v1, e1, f1, o1, y1, d1;
  logic [4:0] fl1;

  always #5 clk = ~clk;

  acq_sequencer u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .rd_req(rd_req),
    .begin_acq(b0), .wr_strobe(w0), .rd_strobe(r0), .rd_valid(v0), .fill(fl0),
    .empty(e0), .full(f0), .overflow(o0), .busy(y0), .done(d0)
  );

  acq_sequencer #(.DEPTH(D1), .CAPTURE_LEN(L1), .SAMPLE_DIV(V1),
                  .ARM_CYCLES(A1), .RD_LAT(R1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .rd_req(rd_req),
    .begin_acq(b1), .wr_strobe(w1), .rd_strobe(r1), .rd_valid(v1), .fill(fl1),
    .empty(e1), .full(f1), .overflow(o1), .busy(y1), .done(d1)
  );

  logic [31:0] got [2];
  assign got[0] = {16'(fl0), 7'd0, b0, w0, r0, v0, e0, f0, o0, y0, d0};
  assign got[1] = {16'(fl1), 7'd0, b1, w1, r1, v1, e1, f1, o1, y1, d1};

  int   n_chk = 0, n_err = 0, cyc = 0;
  mdl_t mdl [2];
  int   n_wr [2], n_val [2], n_done [2];
  bit   saw_rd0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, act, exp);
    end
  endtask

  function automatic mdl_t mdl_rst();
    mdl_t m;
    m.phase = P_IDLE; m.cnt = 0; m.slots = 0; m.fill = 0; m.ovf = 1'b0;
    m.st_prev = 1'b0; m.due = -1; m.last_rd = -1000000;
    return m;
  endfunction

  // One clock of the reference: expected outputs for this cycle, then advance.
  task automatic model_cycle(input int i, output logic [31:0] e);
    mdl_t m;
    bit slot, wr, rd, vld, emp, win;
    m = mdl[i];
    if (!rst_n) m = mdl_rst();
    slot = rst_n && m.phase == P_RUN && (m.cnt % c_dv[i]) == c_dv[i] - 1;
    wr   = slot && m.fill != c_dp[i];
    win  = (m.phase == P_RUN) || (m.phase == P_DRAIN);
    rd   = rst_n && win && rd_req && m.fill >= 4 && (cyc - m.last_rd) > c_rl[i];
    vld  = rst_n && m.due == cyc;
    emp  = m.fill < 4;
    e = {m.fill[15:0], 7'd0, win, wr, rd, vld, emp, m.fill == c_dp[i], m.ovf,
         m.phase != P_IDLE, m.phase == P_DONE};
    if (rst_n) begin
      if (rd) begin m.due = cyc + c_rl[i]; m.last_rd = cyc; end
      m.fill = m.fill + (wr ? 1 : 0) - (rd ? 4 : 0);
      case (m.phase)
        P_IDLE: if (start && !m.st_prev) begin
          m.phase = P_ARM; m.cnt = 0; m.slots = 0; m.fill = 0; m.ovf = 1'b0;
        end
        P_ARM: begin
          m.cnt++;
          if (m.cnt == c_ac[i]) begin m.phase = P_RUN; m.cnt = 0; end
        end
        P_RUN: begin
          if (slot) begin m.slots++; if (!wr) m.ovf = 1'b1; end
          m.cnt++;
          if (m.slots == c_ln[i] || stop) m.phase = P_DRAIN;
        end
        P_DRAIN: if (emp) begin m.fill = 0; m.phase = P_DONE; end
        default: m.phase = P_IDLE;
      endcase
      m.st_prev = start;
    end
    mdl[i] = m;
  endtask

  // Check one cycle at the falling edge, then return just after the rising edge.
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      model_cycle(i, e);
      chk(i == 0 ? "u0_outputs" : "u1_outputs", got[i], e);
    end
    n_wr[0] += int'(w0);  n_val[0] += int'(v0);  n_done[0] += int'(d0);
    n_wr[1] += int'(w1);  n_val[1] += int'(v1);  n_done[1] += int'(d1);
    saw_rd0 = r0;
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 2; i++) begin n_wr[i] = 0; n_val[i] = 0; n_done[i] = 0; end
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  initial begin
    bit found;
    mdl[0] = mdl_rst(); mdl[1] = mdl_rst();
    clr_counts();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; rd_req = 1'b0;
    @(posedge clk); #1;
    run(3);
    chk("rst_empty0", 32'(e0), 1);
    chk("rst_busy0", 32'(y0), 0);
    rst_n = 1'b1;
    run(2);

    // full capture with no reads; small instance overruns its buffer
    pulse_start();
    run(1600);
    chk("cap_fill0", 32'(fl0), 192);
    chk("cap_wr0", n_wr[0], 192);
    chk("cap_nodone0", n_done[0], 0);
    chk("cap_busy0", 32'(y0), 1);
    chk("ovf_flag1", 32'(o1), 1);
    chk("ovf_full1", 32'(f1), 1);
    chk("ovf_wr1", n_wr[1], D1);

    // drain all words
    rd_req = 1'b1;
    run(300);
    chk("drain_val0", n_val[0], 48);
    chk("drain_done0", n_done[0], 1);
    chk("drain_fill0", 32'(fl0), 0);
    chk("drain_idle0", 32'(y0), 0);
    chk("drain_val1", n_val[1], D1 / 4);
    chk("drain_ovf1", 32'(o1), 1);

    // stop after ten writes, two whole words then residual discard
    clr_counts();
    rd_req = 1'b0;
    pulse_start();
    chk("restart_ovf1", 32'(o1), 0);
    run(87);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_fill0", 32'(fl0), 10);
    chk("stop_wr0", n_wr[0], 10);
    rd_req = 1'b1;
    run(60);
    chk("stop_val0", n_val[0], 2);
    chk("stop_done0", n_done[0], 1);
    chk("stop_fill0_end", 32'(fl0), 0);

    // random start pulses and read requests
    for (int k = 0; k < 3000; k++) begin
      start  = ($urandom_range(0, 99) == 0);
      rd_req = ($urandom_range(0, 2) != 0);
      stop   = ($urandom_range(0, 999) == 0);
      step();
    end
    start = 1'b0; stop = 1'b0;

    // reset while a read is in flight
    rd_req = 1'b1;
    run(2);
    pulse_start();
    found = 1'b0;
    for (int k = 0; k < 3000 && !found; k++) begin
      step();
      found = saw_rd0;
    end
    chk("inflight_wait", 32'(found), 1);
    clr_counts();
    rst_n = 1'b0;
    run(2);
    rst_n = 1'b1;
    run(10);
    chk("rst_noval0", n_val[0], 0);
    chk("rst_busy0_after", 32'(y0), 0);
    chk("rst_fill0", 32'(fl0), 0);

    // start held high across completion: exactly one capture each
    clr_counts();
    start = 1'b1;
    run(2000);
    chk("hold_done0", n_done[0], 1);
    chk("hold_done1", n_done[1], 1);
    chk("hold_val0", n_val[0], 48);
    chk("hold_val1", n_val[1], L1 / 4);
    start = 1'b0;
    run(2);
    pulse_start();
    chk("rearm_busy0", 32'(y0), 1);
    chk("rearm_acq0", 32'(b0), 0);
    run(20);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
Controller that sequences one capture in the acquisition buffer. It opens and closes the acquisition window with begin_acq. It produces the write-strobe and read-strobe pulses that the buffer samples on clk. It tracks the buffer fill level so writes never overrun unread data and reads never underrun. A UART/readout consumer requests 48-bit words (4 x 12-bit samples) with rd_req and is told when each word is valid.

Parameters:
DEPTH, 256, buffer capacity in 12-bit samples (power of 2, multiple of 4)
CAPTURE_LEN, 192, samples written per capture (multiple of 4, 4..DEPTH*4)
SAMPLE_DIV, 8, clk cycles between write strobes (>=2)
ARM_CYCLES, 4, cycles begin_acq held low in ARM to reset buffer
RD_LAT, 3, clk cycles from rd_strobe rise to valid data_out

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; rising edge in IDLE starts a capture
stop  in  1  pulse; aborts write phase
rd_req  in  1  level; consumer wants next word
begin_acq  out  1  acquisition window enable to buffer
wr_strobe  out  1  write pulse to buffer (one clk high)
rd_strobe  out  1  read pulse to buffer (one clk high)
rd_valid  out  1  one-clk pulse: buffer data_out words valid
fill  out  $clog2(DEPTH)+1  unread samples in buffer
empty  out  1  fill < 4 (no whole word available)
full  out  1  fill == DEPTH
overflow  out  1  sticky: a write slot was skipped because buffer full
busy  out  1  state != IDLE
done  out  1  one-clk pulse on capture completion

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs 0 except empty=1. Counters cleared. RD_LAT pipeline flushed.
- States: IDLE, ARM, RUN, DRAIN, DONE.
- IDLE: on start rising edge (start registered; edge = start & !start_d) -> ARM. Clear overflow, fill, write count, divider.
- ARM: begin_acq=0 for ARM_CYCLES clks, then -> RUN. begin_acq=1 from the first RUN cycle.
- RUN: divider counts 0..SAMPLE_DIV-1. wr_strobe=1 for exactly one clk when divider==SAMPLE_DIV-1.
  - If full at that slot, suppress the strobe, set overflow. The slot still counts toward CAPTURE_LEN.
  - When write count reaches CAPTURE_LEN, or on stop -> DRAIN. A stop coinciding with a strobe slot: the strobe is issued, then DRAIN.
- DRAIN: no writes. When empty, drop the residual (<4 samples; fill:=0) -> DONE.
- DONE: begin_acq=0, done=1 for one clk -> IDLE. A new capture needs a fresh start edge.
- Read arbitration (RUN and DRAIN only):
  - rd_strobe=1 for one clk when rd_req=1, fill>=4, rd_strobe was 0 last cycle, and no read in flight. Maximum rate is one word per RD_LAT+1 clks.
  - rd_valid pulses exactly RD_LAT clks after the rd_strobe cycle.
  - rd_req in IDLE/ARM/DONE, or while empty, is ignored (held, not queued).
- Fill arithmetic, updated on the strobe cycle:
  - write only: +1
  - read only: -4
  - both: -3
  - fill never wraps; the full/empty guards guarantee this.
- Strobes are high exactly one clk and low at least one clk between pulses, so the buffer's clk-sampled edge detect sees every pulse.
- reset mid-capture: immediate return to IDLE. Outputs take their reset values. An in-flight rd_valid is cancelled.
- start held high after DONE does not retrigger.

Test Plan:
- Default params, start pulse, rd_req=0 -> 4 clks begin_acq=0, then wr_strobe every 8 clks. After 192 strobes: DRAIN, fill=192, no done. Raise rd_req -> 48 rd_strobes, each rd_valid 3 clks later, fill->0, done pulse, begin_acq=0, IDLE.
- CAPTURE_LEN=512, DEPTH=256, no reads -> fill saturates at 256, full=1, 256 slots suppressed, overflow=1, no further wr_strobe. Next start -> overflow cleared.
- rd_req held high throughout, SAMPLE_DIV=2 -> read and write strobes coincide. Fill changes by -3 on those cycles and never underflows. Final fill=0; total rd_valid count = CAPTURE_LEN/4.
- stop after 10 writes -> DRAIN. Two words read (fill 10->2), then fill:=0, done pulse; 2 residual samples discarded.
- rst_n=0 during RUN with a read in flight -> all outputs 0 at once (empty=1), no rd_valid afterwards. After release, IDLE until a new start edge.
- start held high across DONE -> exactly one capture. Drop and re-raise start -> second capture begins with ARM.
